// File: rtl/dbus_peripheral.sv
// Memory-mapped peripheral on the CPU data bus: a TX FIFO with a ready/valid drain port
// and a compare timer. Reads are registered; sticky OVF/HIT flags feed a registered IRQ.
module dbus_peripheral #(
  parameter logic [31:0] BASE  = 32'd4096,
  parameter int          DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] dataBus_Write,
  output logic [31:0] dataBus_Read,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        IRQ
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_STATUS = 3'd1,
    REG_TCTRL  = 3'd2,
    REG_TCOUNT = 3'd3,
    REG_TCMP   = 3'd4
  } reg_e;

  logic [31:0] offset;
  logic        sel;
  reg_e        reg_sel;
  logic        rd;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_tctrl;
  logic        wr_tcount;
  logic        wr_tcmp;

  // Addresses below BASE wrap to a huge offset and therefore fall outside the window.
  assign offset    = ADDR - BASE;
  assign sel       = CS && (offset < 32'd5);
  assign reg_sel   = reg_e'(offset[2:0]);
  assign rd        = sel && !WE;
  assign wr_txdata = sel && WE && (reg_sel == REG_TXDATA);
  assign wr_status = sel && WE && (reg_sel == REG_STATUS);
  assign wr_tctrl  = sel && WE && (reg_sel == REG_TCTRL);
  assign wr_tcount = sel && WE && (reg_sel == REG_TCOUNT);
  assign wr_tcmp   = sel && WE && (reg_sel == REG_TCMP);

  // ---------------------------------------------------------------- TX FIFO
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == 5'd0);
  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  // A same-cycle pop frees the head slot, so a push into a full FIFO is still taken.
  assign push     = wr_txdata && (!full || pop);

  // NOTE: the storage array has no reset; emptiness is tracked by count, so stale words
  // are never visible and the array can map onto plain RAM cells.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem[wr_ptr] <= dataBus_Write;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------- timer / flags
  logic        en;
  logic        auto_reload;
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        ovf;
  logic        hit;
  logic        hit_evt;
  logic        ovf_evt;

  assign hit_evt = en && (tcount == tcmp);
  assign ovf_evt = wr_txdata && full && !pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      tcount      <= '0;
      tcmp        <= '0;
      ovf         <= 1'b0;
      hit         <= 1'b0;
      IRQ         <= 1'b0;
    end else begin
      if (wr_tctrl) begin
        en          <= dataBus_Write[0];
        auto_reload <= dataBus_Write[1];
      end else if (hit_evt && !auto_reload) begin
        en <= 1'b0;
      end

      if (wr_tcount) begin
        tcount <= dataBus_Write;
      end else if (hit_evt) begin
        if (auto_reload) tcount <= '0;
      end else if (en) begin
        tcount <= tcount + 32'd1;
      end

      if (wr_tcmp) tcmp <= dataBus_Write;

      // Set wins over a same-cycle write-1-to-clear so no event is lost.
      if (ovf_evt)                          ovf <= 1'b1;
      else if (wr_status && dataBus_Write[7]) ovf <= 1'b0;
      if (hit_evt)                          hit <= 1'b1;
      else if (wr_status && dataBus_Write[6]) hit <= 1'b0;

      IRQ <= ovf || hit;
    end
  end

  // ------------------------------------------------------------- read port
  logic [31:0] status;
  logic [31:0] rdata_next;

  assign status = {24'b0, ovf, hit, full, empty, count[3:0]};

  // NOTE: rdata_next is defaulted before the case so no path leaves it unassigned,
  // which keeps this block free of inferred latches.
  always_comb begin
    rdata_next = '0;
    if (rd) begin
      case (reg_sel)
        REG_STATUS: rdata_next = status;
        REG_TCTRL:  rdata_next = {30'b0, auto_reload, en};
        REG_TCOUNT: rdata_next = tcount;
        REG_TCMP:   rdata_next = tcmp;
        default:    rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) dataBus_Read <= '0;
    else     dataBus_Read <= rdata_next;
  end

endmodule

// File: tb/tb_dbus_peripheral.sv
// Scoreboard bench for dbus_peripheral: stimulus queues expected read data and TX words,
// a negedge monitor pops and compares whenever the DUT presents a read result or a TX beat.
module tb_dbus_peripheral;

  localparam logic [31:0] A_TXDATA = 32'h0000_1000;
  localparam logic [31:0] A_STATUS = 32'h0000_1001;
  localparam logic [31:0] A_TCTRL  = 32'h0000_1002;
  localparam logic [31:0] A_TCOUNT = 32'h0000_1003;
  localparam logic [31:0] A_TCMP   = 32'h0000_1004;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] dataBus_Write;
  logic [31:0] dataBus_Read;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        IRQ;

  dbus_peripheral #(.BASE(32'd4096), .DEPTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .CS(CS),
    .WE(WE),
    .ADDR(ADDR),
    .dataBus_Write(dataBus_Write),
    .dataBus_Read(dataBus_Read),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [31:0] tx_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic        mon_rd_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    CS = 1'b1; WE = 1'b1; ADDR = addr; dataBus_Write = data;
    sync();
    CS = 1'b0; WE = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    rd_q.push_back('{name: name, val: exp});
    CS = 1'b1; WE = 1'b0; ADDR = addr;
    sync();
    CS = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] data, input bit expect_out);
    if (expect_out) tx_q.push_back(data);
    bus_write(A_TXDATA, data);
  endtask

  // Waits (bounded) until the monitor has consumed every queued TX word.
  task automatic wait_drain(input int max_cycles, output int cycles);
    cycles = 0;
    while (tx_q.size() != 0 && cycles < max_cycles) begin
      @(posedge CLK);
      cycles++;
    end
    #1;
  endtask

  // Monitor: outputs sampled on the falling edge, inputs are stable there.
  initial begin : monitor
    rd_exp_t     e;
    logic [31:0] w;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (mon_rd_pending) begin
          if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected: got 0x%08h with no read queued", dataBus_Read);
          end else begin
            e = rd_q.pop_front();
            check(e.name, dataBus_Read, e.val);
          end
        end else begin
          check("rd_idle_zero", dataBus_Read, 32'h0);
        end
        if (!RST && tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: got 0x%08h with no word queued", tx_data);
          end else begin
            w = tx_q.pop_front();
            check("tx_data", tx_data, w);
          end
        end
        mon_rd_pending = CS && !WE;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int cyc;
    RST = 1'b1; CS = 1'b0; WE = 1'b0; ADDR = '0; dataBus_Write = '0; tx_ready = 1'b0;
    idle(3);
    RST = 1'b0;
    mon_en = 1'b1;

    // Reset state and address decode boundaries
    @(negedge CLK);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    sync();
    bus_read(A_STATUS, 32'h10, "rst_status");
    bus_read(A_TCTRL, 32'h0, "rst_tctrl");
    bus_read(A_TCOUNT, 32'h0, "rst_tcount");
    bus_read(A_TCMP, 32'h0, "rst_tcmp");
    bus_read(A_TXDATA, 32'h0, "txdata_read_zero");
    bus_read(32'h0000_0FFF, 32'h0, "below_base_read");
    bus_read(32'h0000_1005, 32'h0, "above_range_read");
    bus_write(32'h0000_1005, 32'hFFFF_FFFF);
    bus_write(A_TCMP, 32'hDEAD_BEEF);
    bus_read(A_TCMP, 32'hDEAD_BEEF, "tcmp_rw");
    bus_write(A_TCTRL, 32'hFFFF_FFFE);
    bus_read(A_TCTRL, 32'h2, "tctrl_mask");
    bus_write(A_TCTRL, 32'h0);
    bus_read(A_STATUS, 32'h10, "status_after_ignored_write");

    // Three pushes, then in-order drain on consecutive cycles
    push_word(32'h11, 1'b1);
    @(negedge CLK);
    check("t1_valid_rise", 32'(tx_valid), 32'h1);
    sync();
    push_word(32'h22, 1'b1);
    push_word(32'h33, 1'b1);
    bus_read(A_STATUS, 32'h03, "t1_status");
    tx_ready = 1'b1;
    wait_drain(20, cyc);
    tx_ready = 1'b0;
    check("t1_drain_cycles", 32'(cyc), 32'd3);
    @(negedge CLK);
    check("t1_valid_low", 32'(tx_valid), 32'h0);
    sync();

    // Overflow: ninth push dropped, OVF set, IRQ one cycle later, W1C clears it
    for (int i = 0; i < 9; i++) push_word(32'h100 + 32'(i), i < 8);
    @(negedge CLK);
    check("t2_irq_delay", 32'(IRQ), 32'h0);
    sync();
    bus_read(A_STATUS, 32'hA8, "t2_status_ovf");
    @(negedge CLK);
    check("t2_irq_set", 32'(IRQ), 32'h1);
    sync();
    bus_write(A_STATUS, 32'h80);
    bus_read(A_STATUS, 32'h28, "t2_status_clr");
    @(negedge CLK);
    check("t2_irq_clr", 32'(IRQ), 32'h0);
    sync();

    // Push into a full FIFO with a same-cycle pop
    tx_q.push_back(32'h99);
    tx_ready = 1'b1;
    bus_write(A_TXDATA, 32'h99);
    tx_ready = 1'b0;
    bus_read(A_STATUS, 32'h28, "t3_status");
    @(negedge CLK);
    check("t3_irq", 32'(IRQ), 32'h0);
    sync();
    tx_ready = 1'b1;
    wait_drain(40, cyc);
    tx_ready = 1'b0;
    check("t3_drain_cycles", 32'(cyc), 32'd8);
    @(negedge CLK);
    check("t3_valid_low", 32'(tx_valid), 32'h0);
    sync();
    bus_read(A_STATUS, 32'h10, "t3_status_empty");

    // Timer auto-reload: period of 6 cycles with TCMP=5
    bus_write(A_TCMP, 32'd5);
    bus_write(A_TCOUNT, 32'd0);
    bus_write(A_TCTRL, 32'h3);
    for (int i = 0; i < 5; i++) bus_read(A_TCOUNT, 32'(i), "t4_auto_count");
    bus_read(A_STATUS, 32'h10, "t4_at_cmp_no_hit_yet");
    bus_read(A_STATUS, 32'h50, "t4_hit_set");
    for (int i = 1; i <= 5; i++) bus_read(A_TCOUNT, 32'(i), "t4_second_period");
    bus_read(A_TCOUNT, 32'd0, "t4_reload_again");
    @(negedge CLK);
    check("t4_irq_hit", 32'(IRQ), 32'h1);
    sync();
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TCOUNT, 32'd0);
    bus_write(A_STATUS, 32'h40);
    bus_read(A_STATUS, 32'h10, "t4_hit_w1c");
    @(negedge CLK);
    check("t4_irq_clr", 32'(IRQ), 32'h0);
    sync();

    // Timer one-shot: EN clears and TCOUNT holds at TCMP
    bus_write(A_TCTRL, 32'h1);
    for (int i = 0; i < 6; i++) bus_read(A_TCOUNT, 32'(i), "t4_oneshot_count");
    bus_read(A_TCOUNT, 32'd5, "t4_oneshot_hold");
    bus_read(A_TCTRL, 32'h0, "t4_en_cleared");
    bus_read(A_STATUS, 32'h50, "t4_oneshot_hit");
    bus_read(A_TCOUNT, 32'd5, "t4_still_held");

    // CPU write beats increment; a new hit beats W1C
    bus_write(A_TCMP, 32'h0000_FFFF);
    bus_write(A_TCTRL, 32'h1);
    bus_write(A_TCOUNT, 32'h100);
    bus_read(A_TCOUNT, 32'h100, "t5_write_priority");
    bus_read(A_TCOUNT, 32'h101, "t5_resume_count");
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TCOUNT, 32'd0);
    bus_write(A_TCMP, 32'd2);
    bus_write(A_STATUS, 32'h40);
    bus_read(A_STATUS, 32'h10, "t5_hit_cleared");
    bus_write(A_TCTRL, 32'h3);
    idle(2);
    bus_write(A_STATUS, 32'h40);
    bus_read(A_STATUS, 32'h50, "t5_set_beats_clear");
    bus_read(A_TCOUNT, 32'd1, "t5_count_after_reload");

    // Reset mid-drain with a concurrent push, then a read during reset
    for (int i = 0; i < 6; i++) push_word(32'h200 + 32'(i), 1'b1);
    tx_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    tx_ready = 1'b0;
    bus_read(A_STATUS, 32'h44, "t6_status_pre_reset");
    @(negedge CLK);
    check("t6_irq_pre_reset", 32'(IRQ), 32'h1);
    sync();
    RST = 1'b1; CS = 1'b1; WE = 1'b1; ADDR = A_TXDATA; dataBus_Write = 32'h777;
    tx_ready = 1'b1;
    tx_q.delete();
    sync();
    WE = 1'b0; ADDR = A_STATUS; tx_ready = 1'b0;
    rd_q.push_back('{name: "t6_read_during_reset", val: 32'h0});
    @(negedge CLK);
    check("t6_tx_valid_reset", 32'(tx_valid), 32'h0);
    check("t6_irq_reset", 32'(IRQ), 32'h0);
    sync();
    RST = 1'b0; CS = 1'b0;
    bus_read(A_STATUS, 32'h10, "t6_status_after_reset");
    bus_read(A_TCTRL, 32'h0, "t6_tctrl_after_reset");
    @(negedge CLK);
    check("t6_tx_valid_after", 32'(tx_valid), 32'h0);
    check("t6_irq_after", 32'(IRQ), 32'h0);
    sync();

    idle(3);
    check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
